regfile_scoreboard: RTL and testbench

Parametrised multi-port integer register file for the next-generation core, replacing the single-write, two-read register file. Adds N read ports, M write ports, a hardwired-zero register 0, and same-cycle write-to-read bypass. Adds a per-register busy scoreboard that decode uses for hazard detection: set at issue, cleared at writeback. Sits between decode/issue (reads, issue marks) and writeback (writes).

---
 rtl/core_pkg.sv | 8 +
 rtl/regfile_bypass_mux.sv | 36 +++
 rtl/regfile_scoreboard.sv | 98 +++++++++
 tb/tb_regfile_scoreboard.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants: default register-file geometry and the hardwired-zero
// register index.
package core_pkg;
  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 5;
  localparam int REG_ZERO      = 0;
  localparam int NUM_ARCH_REGS = 2 ** ADDR_W_DEF;
endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port data select: same-cycle write bypass (youngest write port wins)
// over the array value, with register 0 forced to zero.
module regfile_bypass_mux
  import core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_WR = 2
) (
  input  logic                     i_bypass_en,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  input  logic [DATA_W-1:0]        i_arr_data,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic                     o_bypass_hit
);

  always_comb begin
    o_rd_data    = i_arr_data;
    o_bypass_hit = 1'b0;
    // Ascending scan so the highest-index (youngest) matching port ends up selected.
    for (int j = 0; j < NUM_WR; j++) begin
      if (i_bypass_en && i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] == i_rd_addr)) begin
        o_rd_data    = i_wr_data[j*DATA_W +: DATA_W];
        o_bypass_hit = 1'b1;
      end
    end
    if (i_rd_addr == ADDR_W'(REG_ZERO)) begin
      o_rd_data    = '0;
      o_bypass_hit = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with write-to-read bypass, hardwired-zero r0,
// and a per-register busy scoreboard (set at issue, cleared at writeback).
module regfile_scoreboard
  import core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_busy_cnt;

  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic [NUM_RD-1:0] w_hit;

  // Ascending port order makes the youngest write win on an address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) r_regs[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO)))
          r_regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Priority, lowest to highest: hold, writeback clear, issue set, flush.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) w_busy_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (iss_en) w_busy_nxt[iss_addr] = 1'b1;
    if (flush) w_busy_nxt = '0;
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int r = 0; r < DEPTH; r++) w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[r]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign busy_cnt = r_busy_cnt;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_rd_addr;
    assign w_rd_addr = rd_addr[i*ADDR_W +: ADDR_W];

    // Bypass is gated by reset so read data is zero for the whole reset window.
    regfile_bypass_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_mux (
      .i_bypass_en  (reset),
      .i_rd_addr    (w_rd_addr),
      .i_arr_data   (r_regs[w_rd_addr]),
      .i_wr_en      (wr_en),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data),
      .o_rd_data    (rd_data[i*DATA_W +: DATA_W]),
      .o_bypass_hit (w_hit[i])
    );

    assign rd_busy[i] = r_busy[w_rd_addr] & ~w_hit[i] & (w_rd_addr != ADDR_W'(REG_ZERO));
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios then randomized traffic, all compared
// against an architectural model of the register file and scoreboard.
module tb_regfile_scoreboard;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic           clk;
  logic           reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             flush;
  logic [AW:0]      busy_cnt;

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] m_regs [32];
  bit   [31:0]   m_busy;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int a);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) v = wr_data[j*DW +: DW];
    return v;
  endfunction

  function automatic bit exp_busy(input int a);
    if (a == 0) return 1'b0;
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int model_cnt();
    return $countones(m_busy);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    m_busy = '0;
  endtask

  task automatic model_update();
    for (int j = 0; j < NW; j++) begin
      if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
        m_regs[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
        m_busy[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    if (flush) m_busy = '0;
  endtask

  task automatic check_comb();
    for (int i = 0; i < NR; i++) begin
      chk("rd_data", rd_data[i*DW +: DW], exp_rd(int'(rd_addr[i*AW +: AW])));
      chk("rd_busy", {31'b0, rd_busy[i]}, {31'b0, exp_busy(int'(rd_addr[i*AW +: AW]))});
    end
  endtask

  task automatic step();
    #1;
    check_comb();
    @(posedge clk);
    model_update();
    #1;
    chk("busy_cnt", 32'(busy_cnt), 32'(model_cnt()));
  endtask

  task automatic idle_inputs();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic set_wr(input int j, input int a, input logic [DW-1:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*AW +: AW] = AW'(a);
    wr_data[j*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input int a);
    rd_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic issue(input int a);
    iss_en = 1'b1;
    iss_addr = AW'(a);
  endtask

  // Asynchronous reset pulse with immediate checks, released away from the edge.
  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < NR; i++) begin
      chk("rst_rd_data", rd_data[i*DW +: DW], 32'h0);
      chk("rst_rd_busy", {31'b0, rd_busy[i]}, 32'h0);
    end
    chk("rst_busy_cnt", 32'(busy_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    rd_addr = '0;
    idle_inputs();
    model_reset();
    set_rd(0, 5); set_rd(1, 8);
    #12;
    chk("por_rd_data", rd_data[DW-1:0], 32'h0);
    chk("por_busy_cnt", 32'(busy_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Mid-run reset after r5 written and r8 busy
    set_wr(0, 5, 32'hDEADBEEF); issue(8);
    step();
    idle_inputs();
    #1;
    chk("t1_r5_pre", rd_data[DW-1:0], 32'hDEADBEEF);
    chk("t1_r8_busy_pre", {31'b0, rd_busy[1]}, 32'h1);
    pulse_reset();

    // Zero register
    set_wr(0, 0, 32'h12345678); issue(0); set_rd(0, 0); set_rd(1, 0);
    #1;
    chk("t2_r0_data", rd_data[DW-1:0], 32'h0);
    step();
    idle_inputs();
    chk("t2_cnt", 32'(busy_cnt), 32'h0);

    // Bypass with youngest-port priority
    set_wr(0, 7, 32'hAAAA0000); set_wr(1, 7, 32'h5555FFFF); set_rd(0, 7); set_rd(1, 7);
    #1;
    chk("t3_bypass", rd_data[DW-1:0], 32'h5555FFFF);
    step();
    idle_inputs();
    #1;
    chk("t3_stored", rd_data[DW-1:0], 32'h5555FFFF);

    // Scoreboard lifecycle
    issue(3); set_rd(0, 3);
    step();
    idle_inputs();
    #1;
    chk("t4_busy", {31'b0, rd_busy[0]}, 32'h1);
    chk("t4_cnt1", 32'(busy_cnt), 32'h1);
    set_wr(1, 3, 32'h10);
    #1;
    chk("t4_busy_bypassed", {31'b0, rd_busy[0]}, 32'h0);
    step();
    idle_inputs();
    chk("t4_cnt0", 32'(busy_cnt), 32'h0);

    // Issue/writeback collision
    issue(9); set_rd(0, 9);
    step();
    issue(9); set_wr(0, 9, 32'h42);
    step();
    idle_inputs();
    #1;
    chk("t5_data", rd_data[DW-1:0], 32'h42);
    chk("t5_busy", {31'b0, rd_busy[0]}, 32'h1);
    chk("t5_cnt", 32'(busy_cnt), 32'h1);

    // Flush overrides a simultaneous issue; data retained
    idle_inputs(); issue(1); step();
    idle_inputs(); issue(2); step();
    idle_inputs(); issue(4); step();
    idle_inputs();
    chk("t6_cnt4", 32'(busy_cnt), 32'h4);
    flush = 1'b1; issue(6);
    step();
    idle_inputs();
    chk("t6_cnt0", 32'(busy_cnt), 32'h0);
    set_rd(0, 9); set_rd(1, 6);
    #1;
    chk("t6_data_kept", rd_data[DW-1:0], 32'h42);
    chk("t6_r6_not_busy", {31'b0, rd_busy[1]}, 32'h0);

    // Randomized traffic, addresses biased to a small window to force collisions
    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      for (int j = 0; j < NW; j++) begin
        if ($urandom_range(0, 1) == 1)
          set_wr(j, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31), $urandom);
      end
      if ($urandom_range(0, 2) != 0) issue(($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 2) == 0) set_rd(i, int'(wr_addr[(i % NW)*AW +: AW]));
        else set_rd(i, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      end
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
